// File: rtl/mul_sched.sv
// mul_sched: arbitration and sequencing controller for a shared 64x64 multiplier.
// Two requesters compete for a single multiplier. The operands are registered and
// held for LATENCY cycles, so the combinational product can be timed as a multicycle
// path. The result is then returned over a valid/ready response channel.
// Optional feature macro: MUL_SCHED_RR_EN selects round-robin arbitration.
// When the macro is not defined, arbitration is fixed priority with requester 0 highest.

// multiply: combinational 64x64 multiplier.
// flag 00 = low 64 bits, 01 = signed x signed high,
// 10 = signed x unsigned high, 11 = unsigned x unsigned high.
module multiply (
    input  logic [63:0] in1,
    input  logic [63:0] in2,
    input  logic [1:0]  flag,
    output logic [63:0] out
);
    logic         sign1;
    logic         sign2;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] p;

    // Extend both operands to 128 bits according to flag signedness.
    // The low 128 bits of the product are then exact for every mode.
    always_comb begin
        sign1 = (flag == 2'b01 || flag == 2'b10) & in1[63];
        sign2 = (flag == 2'b01) & in2[63];
        a     = {{64{sign1}}, in1};
        b     = {{64{sign2}}, in2};
        p     = a * b;
        out   = (flag == 2'b00) ? p[63:0] : p[127:64];
    end
endmodule

module mul_sched #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_in1_0,
    input  logic [63:0] req_in2_0,
    input  logic [1:0]  req_flag_0,
    input  logic [63:0] req_in1_1,
    input  logic [63:0] req_in2_1,
    input  logic [1:0]  req_flag_1,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [63:0] resp_data,
    output logic        busy
);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] op_in1;
    logic [63:0] op_in2;
    logic [1:0]  op_flag;
    logic        owner;
    logic [3:0]  cnt;
    logic [63:0] result;
    logic        last_grant;
    logic        g;
    logic [63:0] mul_out;

    multiply u_multiply (
        .in1  (op_in1),
        .in2  (op_in2),
        .flag (op_flag),
        .out  (mul_out)
    );

`ifdef MUL_SCHED_RR_EN
    // Round-robin: on contention, grant the requester that was not granted last.
    always_comb begin
        if (req_valid == 2'b11) g = ~last_grant;
        else                    g = ~req_valid[0];
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        g = ~req_valid[0];
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic. A flush overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_ready != 2'b00)    state_next = BUSY;
            BUSY: if (cnt == 4'd0)           state_next = DONE;
            DONE: if (resp_ready[owner])     state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Outputs decoded from the state. req_ready is suppressed during reset because a
    // request accepted in that cycle would be discarded by the reset.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        busy       = (state != IDLE);
        if (state == IDLE && !rst) req_ready[g] = req_valid[g] & ~flush;
        if (state == DONE)         resp_valid[owner] = 1'b1;
    end

    assign resp_data = result;

    // Datapath: operand capture on handshake, latency countdown, and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_in1     <= '0;
            op_in2     <= '0;
            op_flag    <= '0;
            owner      <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            last_grant <= 1'b1;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (req_ready != 2'b00) begin
                        op_in1     <= g ? req_in1_1  : req_in1_0;
                        op_in2     <= g ? req_in2_1  : req_in2_0;
                        op_flag    <= g ? req_flag_1 : req_flag_0;
                        owner      <= g;
                        last_grant <= g;
                        cnt        <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) cnt    <= cnt - 4'd1;
                    else             result <= mul_out;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: scoreboard bench for mul_sched.
// Expected responses are queued when a request handshake happens. A separate monitor
// pops the queue and compares each response when it is consumed. A second instance
// with LATENCY=4 is used for the reset-mid-operation case.
module tb_mul_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready, req_ready_4;
    logic [63:0] req_in1_0, req_in2_0, req_in1_1, req_in2_1;
    logic [1:0]  req_flag_0, req_flag_1;
    logic [1:0]  resp_valid, resp_valid_4;
    logic [1:0]  resp_ready;
    logic [63:0] resp_data, resp_data_4;
    logic        busy, busy_4;

    typedef struct {
        logic        port;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mul_sched #(.LATENCY(2)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1_0(req_in1_0), .req_in2_0(req_in2_0), .req_flag_0(req_flag_0),
        .req_in1_1(req_in1_1), .req_in2_1(req_in2_1), .req_flag_1(req_flag_1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .busy(busy)
    );

    mul_sched #(.LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready_4),
        .req_in1_0(req_in1_0), .req_in2_0(req_in2_0), .req_flag_0(req_flag_0),
        .req_in1_1(req_in1_1), .req_in2_1(req_in2_1), .req_flag_1(req_flag_1),
        .resp_valid(resp_valid_4), .resp_ready(resp_ready),
        .resp_data(resp_data_4), .busy(busy_4)
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: compare each response of the LATENCY=2 instance in the cycle it is consumed.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (resp_valid & resp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%b required=none", resp_valid);
            end else begin
                e = sb.pop_front();
                check2("resp_port", resp_valid, e.port ? 2'b10 : 2'b01);
                check64("resp_data", resp_data, e.data);
            end
        end
    end

    // Present one request and wait for its handshake; optionally queue the expected result.
    task automatic issue(input int p, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] f, input logic [63:0] e, input bit push);
        bit   ok = 0;
        exp_t x;
        if (p == 0) begin
            req_in1_0 = a; req_in2_0 = b; req_flag_0 = f; req_valid = 2'b01;
        end else begin
            req_in1_1 = a; req_in2_1 = b; req_flag_1 = f; req_valid = 2'b10;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[p]) ok = 1;
        end
        if (!ok) fail_timeout("handshake");
        else if (push) begin
            x.port = (p != 0);
            x.data = e;
            sb.push_back(x);
        end
        @(posedge clk); #1;
        req_valid = '0;
        req_in1_0 = {$urandom, $urandom}; req_in2_0 = {$urandom, $urandom};
        req_in1_1 = {$urandom, $urandom}; req_in2_1 = {$urandom, $urandom};
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !busy_4) ok = 1;
        end
        if (!ok) fail_timeout("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic wait_resp(input bit which4, input string name);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if ((which4 ? resp_valid_4 : resp_valid) != 2'b00) ok = 1;
        end
        if (!ok) fail_timeout(name);
    endtask

    logic [63:0] hv_a [5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] hv_b [5] = '{64'd2, 64'd2, 64'd2,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [1:0]  hv_f [5] = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b01};
    logic [63:0] hv_e [5] = '{64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
    int          hv_p [5] = '{0, 0, 1, 1, 1};

`ifdef MUL_SCHED_RR_EN
    logic [1:0] order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    logic [1:0] order [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        exp_t x;
        bit   ok;
        rst = 1'b1; flush = 1'b0; req_valid = '0; resp_ready = 2'b11;
        req_in1_0 = '0; req_in2_0 = '0; req_flag_0 = '0;
        req_in1_1 = '0; req_in2_1 = '0; req_flag_1 = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check2("rst_req_ready", req_ready, 2'b00);
        check2("rst_resp_valid", resp_valid, 2'b00);
        check64("rst_resp_data", resp_data, 64'h0);
        check2("rst_busy", {1'b0, busy}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;

        // Signed low product with exact response latency.
        issue(0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 64'hFFFF_FFFF_FFFF_FFFA, 1);
        @(negedge clk); check2("lat_e0", resp_valid, 2'b00);
        check2("busy_e0", {1'b0, busy}, 2'b01);
        @(negedge clk); check2("lat_e1", resp_valid, 2'b00);
        @(negedge clk); check2("lat_e2", resp_valid, 2'b01);
        wait_idle();

        // High-half variants, over both ports.
        for (int k = 0; k < 5; k++) begin
            issue(hv_p[k], hv_a[k], hv_b[k], hv_f[k], hv_e[k], 1);
            wait_idle();
        end

        // Contention with both requesters valid continuously.
        req_in1_0 = 64'd5; req_in2_0 = 64'd7; req_flag_0 = 2'b00;
        req_in1_1 = 64'd6; req_in2_1 = 64'd7; req_flag_1 = 2'b00;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ok = 0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                if (req_ready != 2'b00) ok = 1;
            end
            if (!ok) fail_timeout("contention_grant");
            else begin
                check2($sformatf("grant_%0d", k), req_ready, order[k]);
                x.port = req_ready[1];
                x.data = req_ready[1] ? 64'd42 : 64'd35;
                sb.push_back(x);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_idle();

        // Backpressure: response held and stable, with no new acceptance.
        resp_ready = 2'b00;
        issue(0, 64'h10, 64'h10, 2'b00, 64'h100, 1);
        wait_resp(0, "bp_resp");
        for (int j = 0; j < 5; j++) begin
            @(posedge clk); #1;
            req_valid = 2'b10;
            @(negedge clk);
            check2("bp_valid", resp_valid, 2'b01);
            check64("bp_data", resp_data, 64'h100);
            check2("bp_req_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1;
        resp_ready = 2'b11; req_valid = '0;
        @(negedge clk);
        @(negedge clk); check2("bp_idle", {1'b0, busy}, 2'b00);
        wait_idle();

        // Flush in the first BUSY cycle.
        issue(0, 64'd9, 64'd9, 2'b00, 64'd0, 0);
        flush = 1'b1; req_valid = 2'b01;
        @(negedge clk); check2("flush_busy_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = '0;
        @(negedge clk); check2("flush_busy_idle", {1'b0, busy}, 2'b00);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); check2("flush_busy_noresp", resp_valid, 2'b00);
        end
        wait_idle();

        // Flush in the DONE state.
        resp_ready = 2'b00;
        issue(0, 64'd9, 64'd9, 2'b00, 64'd0, 0);
        wait_resp(0, "flush_done_resp");
        @(posedge clk); #1;
        flush = 1'b1; req_valid = 2'b01;
        @(negedge clk); check2("flush_done_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = '0; resp_ready = 2'b11;
        @(negedge clk);
        check2("flush_done_idle", {1'b0, busy}, 2'b00);
        check2("flush_done_noresp", resp_valid, 2'b00);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); check2("flush_done_noresp2", resp_valid, 2'b00);
        end
        wait_idle();

        // Reset in BUSY on the LATENCY=4 instance, then a contended request.
        issue(0, 64'd2, 64'd3, 2'b00, 64'd0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check2("rst4_req_ready", req_ready_4, 2'b00);
        check2("rst4_resp_valid", resp_valid_4, 2'b00);
        check64("rst4_resp_data", resp_data_4, 64'h0);
        check2("rst4_busy", {1'b0, busy_4}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        req_in1_0 = 64'd5; req_in2_0 = 64'd7; req_flag_0 = 2'b00;
        req_in1_1 = 64'd6; req_in2_1 = 64'd7; req_flag_1 = 2'b00;
        req_valid = 2'b11;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (req_ready_4 != 2'b00) ok = 1;
        end
        if (!ok) fail_timeout("rst4_grant");
        else begin
            check2("rst4_grant", req_ready_4, 2'b01);
            check2("rst_grant", req_ready, 2'b01);
            x.port = 1'b0;
            x.data = 64'd35;
            sb.push_back(x);
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_resp(1, "rst4_resp");
        check2("rst4_resp_port", resp_valid_4, 2'b01);
        check64("rst4_resp_data_after", resp_data_4, 64'd35);
        wait_idle();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_sched.md
# mul_sched

Sequencing and arbitration controller for the shared 64-bit integer multiplier (`multiply`: flag 00 = MUL low, 01 = MULH, 10 = MULHSU, 11 = MULHU).
- Accepts multiply requests from two requesters (port 0: integer execute pipeline, port 1: secondary issue/coprocessor path) and grants one at a time.
- Latches operands into the multiplier for a fixed multi-cycle window so the combinational 64x64 product can be timed across several cycles.
- Returns the 64-bit result to the granted requester over a valid/ready response channel.

## Interface
Parameters:
- `LATENCY`, default 2: cycles operands are held at the multiplier before the result is captured; legal range 1..15.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flush` input 1: synchronous abort of any in-flight or unconsumed operation.
- `req_valid` input 2: bit i is request valid from requester i.
- `req_ready` output 2: bit i is request accepted from requester i; at most one bit set.
- `req_in1_0`, `req_in2_0` input 64 each: operands, requester 0.
- `req_flag_0` input 2: multiply flag, requester 0.
- `req_in1_1`, `req_in2_1` input 64 each: operands, requester 1.
- `req_flag_1` input 2: multiply flag, requester 1.
- `resp_valid` output 2: bit i is result valid for requester i; at most one bit set.
- `resp_ready` input 2: bit i is requester i consuming the result.
- `resp_data` output 64: result, shared by both requesters and qualified by `resp_valid`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- Internal registers: `op_in1`, `op_in2` (64 bits each), `op_flag` (2), `owner` (1), `cnt` (4), `result` (64), `last_grant` (1).
- Internal instance: one `multiply` driven from `op_in1`, `op_in2`, `op_flag`.
- FSM states: IDLE, BUSY, DONE.
- **IDLE**
  - Grant `g` is computed combinationally from `req_valid`.
  - `req_ready[g] = req_valid[g] & ~flush`.
  - On a handshake: latch operands and flag of `g`, set `owner = g`, `last_grant = g`, `cnt = LATENCY-1`, go to BUSY.
- **BUSY**
  - `req_ready = 0`.
  - If `cnt != 0`: decrement `cnt`.
  - If `cnt == 0`: capture `result <= multiply.out`, go to DONE.
- **DONE**
  - `resp_valid[owner] = 1`, `resp_data = result`.
  - When `resp_ready[owner]` is high at a clock edge: go to IDLE.
  - `resp_ready` of the non-owner is ignored.
  - No new request is accepted in the DONE cycle; there is no bypass.
- **Flush** (any state): next state is IDLE, `resp_valid` is 0 from the next cycle, `last_grant` is unchanged.
  - `req_ready` is 0 while `flush` is high, so no request is accepted in a flush cycle.
- **Reset**: state IDLE, `last_grant = 1`, `cnt = 0`, `result = 0`, `op_* = 0`, `owner = 0`.
  - All outputs 0 at reset: `req_ready`, `resp_valid`, `resp_data`, `busy`.
- Reset during BUSY or DONE: the operation is discarded and no response is issued.
- Width rules: the result is exactly the 64-bit slice selected by `multiply`; there is no sign or zero extension inside this block.
- `resp_data` reads the `result` register in every state and is meaningful only while `resp_valid` is high.

## Timing
- Request accepted at edge E0 → `busy` high from E0.
- `resp_valid` high after edge E0+LATENCY.
- Minimum request-to-request spacing is LATENCY+2 cycles (response consumed in its first valid cycle, next request accepted in IDLE).
- Operands must be stable only during the handshake cycle; they are registered afterwards.
- `req_ready` is combinational from `req_valid`, state and `flush`. It does not depend on `resp_ready`.
- `resp_valid` and `resp_data` are registered-state outputs with no combinational path from inputs.

## Configuration
- `MUL_SCHED_RR_EN` defined: round-robin arbitration.
  - When both requesters are valid in IDLE, grant goes to `~last_grant`.
  - After reset, requester 0 wins the first contention.
- `MUL_SCHED_RR_EN` undefined: fixed priority, requester 0 always wins.
  - `last_grant` is still maintained but is not used.
- With a single valid requester, both modes grant that requester.

## Test plan
- **Signed low.** Requester 0 sends `in1 = 3`, `in2 = 0xFFFF_FFFF_FFFF_FFFE` (−2), flag 00, with `LATENCY = 2`.
  - Required: `resp_valid = 2'b01` two edges after acceptance, `resp_data = 0xFFFF_FFFF_FFFF_FFFA`.
- **High variants.**
  - `in1 = 0xFFFF_FFFF_FFFF_FFFF`, `in2 = 2`, flag 11 → `resp_data = 0x1`.
  - Same operands, flag 10 → `resp_data = 0xFFFF_FFFF_FFFF_FFFF`.
  - Same operands, flag 01 → `resp_data = 0xFFFF_FFFF_FFFF_FFFF`.
- **Contention.** Both requesters hold `req_valid` continuously for 4 operations.
  - With `MUL_SCHED_RR_EN`: grant order 0, 1, 0, 1.
  - Without it: grant order 0, 0, 0, 0, and `req_ready[1]` is never asserted.
- **Backpressure.** `resp_ready` is held low for 5 cycles after `resp_valid` rises.
  - Required: `resp_valid` and `resp_data` stable for all 5 cycles, and `req_ready` stays 0 throughout.
  - Release `resp_ready` → IDLE on the next edge.
- **Flush.** Pulse `flush` in the first BUSY cycle, then in the DONE state.
  - Required: in both cases no `resp_valid` afterwards, `busy` is 0 next cycle, and a request presented during the flush cycle is not accepted.
- **Reset mid-operation.** Assert `rst` in BUSY with `LATENCY = 4`.
  - Required: all outputs 0 next cycle, and the first contended grant after reset goes to requester 0.
